// File: rtl/vga_plot_arbiter3.sv
// Round-robin 3:1 arbiter for the VGA plot port with a one-cycle turnaround between owners.
// Optional forced release after HOLD_MAX grant cycles when ARB_TIMEOUT_EN is defined.
module vga_plot_arbiter3 #(
  parameter int unsigned HOLD_MAX = 4095,
  parameter int unsigned HOLD_W   = 12
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] req,
  input  logic [2:0] plot_in,
  output logic [1:0] sel,
  output logic [2:0] gnt,
  output logic       plot_out,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

  state_t     state, state_d;
  logic [1:0] sel_d;
  logic [2:0] gnt_d;
  logic       busy_d;
  logic [1:0] last, last_d;
  logic [1:0] winner;
  logic [1:0] cand;
  logic       found;
  logic       timeout;

  // Elaboration guard: the hold counter must be able to represent HOLD_MAX.
  if (64'(HOLD_MAX) >= (64'd1 << HOLD_W)) begin : g_hold_w_check
    $error("vga_plot_arbiter3: HOLD_W too narrow for HOLD_MAX");
  end

`ifdef ARB_TIMEOUT_EN
  logic [HOLD_W-1:0] hold;

  // Counts consecutive GRANT cycles; zero outside GRANT so entry starts from 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      hold <= '0;
    end else if (state == GRANT) begin
      if (hold != '1) hold <= hold + HOLD_W'(1);
    end else begin
      hold <= '0;
    end
  end

  // The current cycle is the HOLD_MAX-th GRANT cycle of this owner.
  assign timeout = (state == GRANT) && (hold == HOLD_W'(HOLD_MAX - 1));
`else
  assign timeout = 1'b0;
`endif

  // Round-robin pick: search from last+1, so the previous owner comes last.
  always_comb begin
    winner = last;
    found  = 1'b0;
    cand   = 2'd0;
    for (int k = 1; k <= 3; k++) begin
      cand = 2'((int'(last) + k) % 3);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state;
    sel_d   = sel;
    gnt_d   = gnt;
    busy_d  = busy;
    last_d  = last;
    unique case (state)
      IDLE, TURN: begin
        if (|req) begin
          state_d = GRANT;
          sel_d   = winner;
          gnt_d   = 3'b001 << winner;
          last_d  = winner;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
          gnt_d   = '0;
          busy_d  = 1'b0;
        end
      end
      GRANT: begin
        if (!req[sel] || timeout) begin
          state_d = TURN;
          gnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      sel   <= 2'd0;
      gnt   <= 3'b000;
      busy  <= 1'b0;
      last  <= 2'd2;
    end else begin
      state <= state_d;
      sel   <= sel_d;
      gnt   <= gnt_d;
      busy  <= busy_d;
      last  <= last_d;
    end
  end

  // Only the owner's strobe reaches the adapter, and only while it holds the grant.
  assign plot_out = plot_in[sel] & (state == GRANT);

endmodule

// File: tb/tb_vga_plot_arbiter3.sv
// Self-checking bench for vga_plot_arbiter3: per-cycle expectations are queued as stimulus
// is applied and popped when the post-edge outputs are sampled. Honours ARB_TIMEOUT_EN.
module tb_vga_plot_arbiter3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] req = 3'b000;
  logic [2:0] plot_in = 3'b000;
  logic [1:0] sel;
  logic [2:0] gnt;
  logic       plot_out;
  logic       busy;

  int checks = 0;
  int passes = 0;

  typedef struct packed {
    logic       rst;
    logic [2:0] req;
    logic [2:0] plot;
    logic [2:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       pout;
  } row_t;

  typedef struct packed {
    logic [2:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       pout;
  } exp_t;

  exp_t sbq[$];

  vga_plot_arbiter3 #(.HOLD_MAX(8), .HOLD_W(12)) dut (
    .clock(clock),
    .reset(reset),
    .req(req),
    .plot_in(plot_in),
    .sel(sel),
    .gnt(gnt),
    .plot_out(plot_out),
    .busy(busy)
  );

  always #5 clock = ~clock;

  function automatic row_t mk(input logic rst, input logic [2:0] rq, input logic [2:0] pl,
                              input logic [2:0] g, input logic [1:0] s, input logic b,
                              input logic po);
    return '{rst, rq, pl, g, s, b, po};
  endfunction

  // Drive one cycle of inputs, queue what the outputs must be after the edge, then wait.
  task automatic apply(input row_t r);
    reset   = r.rst;
    req     = r.req;
    plot_in = r.plot;
    sbq.push_back('{r.gnt, r.sel, r.busy, r.pout});
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    row_t rows[$];
    exp_t e, g;
    rows = '{mk(1, 3'b111, 3'b111, 3'b000, 2'd0, 0, 0),
             mk(1, 3'b111, 3'b111, 3'b000, 2'd0, 0, 0)};
    foreach (rows[i]) begin
      apply(rows[i]);
      e = sbq.pop_front();
      g = '{gnt, sel, busy, plot_out};
      checks++;
      if (g !== e) $display("FAIL reset[%0d] got gnt=%b sel=%0d busy=%b plot=%b want gnt=%b sel=%0d busy=%b plot=%b",
                            i, g.gnt, g.sel, g.busy, g.pout, e.gnt, e.sel, e.busy, e.pout);
      else passes++;
    end
  endtask

  task automatic test_round_robin();
    row_t rows[$];
    exp_t e, g;
    rows = '{mk(0, 3'b111, 3'b000, 3'b001, 2'd0, 1, 0),
             mk(0, 3'b110, 3'b000, 3'b000, 2'd0, 1, 0),
             mk(0, 3'b110, 3'b000, 3'b010, 2'd1, 1, 0),
             mk(0, 3'b100, 3'b000, 3'b000, 2'd1, 1, 0),
             mk(0, 3'b100, 3'b000, 3'b100, 2'd2, 1, 0),
             mk(0, 3'b001, 3'b000, 3'b000, 2'd2, 1, 0),
             mk(0, 3'b001, 3'b000, 3'b001, 2'd0, 1, 0),
             mk(0, 3'b000, 3'b000, 3'b000, 2'd0, 1, 0),
             mk(0, 3'b000, 3'b000, 3'b000, 2'd0, 0, 0)};
    foreach (rows[i]) begin
      apply(rows[i]);
      e = sbq.pop_front();
      g = '{gnt, sel, busy, plot_out};
      checks++;
      if (g !== e) $display("FAIL round_robin[%0d] got gnt=%b sel=%0d busy=%b plot=%b want gnt=%b sel=%0d busy=%b plot=%b",
                            i, g.gnt, g.sel, g.busy, g.pout, e.gnt, e.sel, e.busy, e.pout);
      else passes++;
    end
  endtask

  // Owner y: only plot_in[1] passes, and nothing passes in TURN or IDLE.
  task automatic test_plot_gating();
    row_t rows[$];
    exp_t e, g;
    rows = '{mk(0, 3'b010, 3'b101, 3'b010, 2'd1, 1, 0),
             mk(0, 3'b010, 3'b010, 3'b010, 2'd1, 1, 1),
             mk(0, 3'b111, 3'b101, 3'b010, 2'd1, 1, 0),
             mk(0, 3'b111, 3'b111, 3'b010, 2'd1, 1, 1),
             mk(0, 3'b101, 3'b111, 3'b000, 2'd1, 1, 0),
             mk(0, 3'b000, 3'b111, 3'b000, 2'd1, 0, 0)};
    foreach (rows[i]) begin
      apply(rows[i]);
      e = sbq.pop_front();
      g = '{gnt, sel, busy, plot_out};
      checks++;
      if (g !== e) $display("FAIL plot_gating[%0d] got gnt=%b sel=%0d busy=%b plot=%b want gnt=%b sel=%0d busy=%b plot=%b",
                            i, g.gnt, g.sel, g.busy, g.pout, e.gnt, e.sel, e.busy, e.pout);
      else passes++;
    end
  endtask

  task automatic test_single_z();
    row_t rows[$];
    exp_t e, g;
    for (int p = 0; p < 3; p++) begin
      rows.push_back(mk(0, 3'b100, 3'b100, 3'b100, 2'd2, 1, 1));
      rows.push_back(mk(0, 3'b000, 3'b100, 3'b000, 2'd2, 1, 0));
      rows.push_back(mk(0, 3'b000, 3'b100, 3'b000, 2'd2, 0, 0));
    end
    foreach (rows[i]) begin
      apply(rows[i]);
      e = sbq.pop_front();
      g = '{gnt, sel, busy, plot_out};
      checks++;
      if (g !== e || sel === 2'd3) $display("FAIL single_z[%0d] got gnt=%b sel=%0d busy=%b plot=%b want gnt=%b sel=%0d busy=%b plot=%b",
                            i, g.gnt, g.sel, g.busy, g.pout, e.gnt, e.sel, e.busy, e.pout);
      else passes++;
    end
  endtask

  task automatic test_mid_reset();
    row_t rows[$];
    exp_t e, g;
    rows = '{mk(0, 3'b010, 3'b010, 3'b010, 2'd1, 1, 1),
             mk(1, 3'b010, 3'b010, 3'b000, 2'd0, 0, 0),
             mk(0, 3'b011, 3'b000, 3'b001, 2'd0, 1, 0),
             mk(0, 3'b010, 3'b000, 3'b000, 2'd0, 1, 0),
             mk(0, 3'b010, 3'b000, 3'b010, 2'd1, 1, 0),
             mk(0, 3'b000, 3'b000, 3'b000, 2'd1, 1, 0),
             mk(0, 3'b000, 3'b000, 3'b000, 2'd1, 0, 0)};
    foreach (rows[i]) begin
      apply(rows[i]);
      e = sbq.pop_front();
      g = '{gnt, sel, busy, plot_out};
      checks++;
      if (g !== e) $display("FAIL mid_reset[%0d] got gnt=%b sel=%0d busy=%b plot=%b want gnt=%b sel=%0d busy=%b plot=%b",
                            i, g.gnt, g.sel, g.busy, g.pout, e.gnt, e.sel, e.busy, e.pout);
      else passes++;
    end
  endtask

  // Owner drops while others request: TURN first, then the next in rotation wins.
  task automatic test_back_to_back();
    row_t rows[$];
    exp_t e, g;
    rows = '{mk(0, 3'b110, 3'b000, 3'b100, 2'd2, 1, 0),
             mk(0, 3'b011, 3'b000, 3'b000, 2'd2, 1, 0),
             mk(0, 3'b011, 3'b000, 3'b001, 2'd0, 1, 0),
             mk(0, 3'b010, 3'b000, 3'b000, 2'd0, 1, 0),
             mk(0, 3'b010, 3'b000, 3'b010, 2'd1, 1, 0),
             mk(0, 3'b000, 3'b000, 3'b000, 2'd1, 1, 0),
             mk(0, 3'b000, 3'b000, 3'b000, 2'd1, 0, 0)};
    foreach (rows[i]) begin
      apply(rows[i]);
      e = sbq.pop_front();
      g = '{gnt, sel, busy, plot_out};
      checks++;
      if (g !== e) $display("FAIL back_to_back[%0d] got gnt=%b sel=%0d busy=%b plot=%b want gnt=%b sel=%0d busy=%b plot=%b",
                            i, g.gnt, g.sel, g.busy, g.pout, e.gnt, e.sel, e.busy, e.pout);
      else passes++;
    end
  endtask

  // req=011 held from IDLE with last=1: owner 0 first.
  task automatic test_hold();
    row_t rows[$];
    exp_t e, g;
`ifdef ARB_TIMEOUT_EN
    for (int c = 0; c < 8; c++) rows.push_back(mk(0, 3'b011, 3'b001, 3'b001, 2'd0, 1, 1));
    rows.push_back(mk(0, 3'b011, 3'b001, 3'b000, 2'd0, 1, 0));
    for (int c = 0; c < 8; c++) rows.push_back(mk(0, 3'b011, 3'b001, 3'b010, 2'd1, 1, 0));
    rows.push_back(mk(0, 3'b011, 3'b001, 3'b000, 2'd1, 1, 0));
    rows.push_back(mk(0, 3'b011, 3'b001, 3'b001, 2'd0, 1, 1));
`else
    for (int c = 0; c < 20; c++) rows.push_back(mk(0, 3'b011, 3'b001, 3'b001, 2'd0, 1, 1));
`endif
    rows.push_back(mk(0, 3'b000, 3'b000, 3'b000, 2'd0, 1, 0));
    rows.push_back(mk(0, 3'b000, 3'b000, 3'b000, 2'd0, 0, 0));
    foreach (rows[i]) begin
      apply(rows[i]);
      e = sbq.pop_front();
      g = '{gnt, sel, busy, plot_out};
      checks++;
      if (g !== e) $display("FAIL hold[%0d] got gnt=%b sel=%0d busy=%b plot=%b want gnt=%b sel=%0d busy=%b plot=%b",
                            i, g.gnt, g.sel, g.busy, g.pout, e.gnt, e.sel, e.busy, e.pout);
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_plot_gating();
    test_single_z();
    test_mid_reset();
    test_back_to_back();
    test_hold();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
